aes_block_sequencer: RTL and testbench

Initiator-side controller for the single-block AES core's start/done handshake. It accepts 128-bit blocks from an upstream valid/ready stream, drives the core's start/encrypt/data/key inputs, waits for the done pulse, and presents results on a downstream valid/ready stream. It also counts completed blocks and flags a hung core via a watchdog. It sits between the DMA/stream fabric and the AES core.

---
 rtl/aes_block_sequencer.sv | 155 +++++++++++++++
 tb/tb_aes_block_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_sequencer.sv
// Start/done handshake controller for a single-block AES core, with block counter and watchdog.
// Build option: define AES_SEQ_CBC_EN to compile in CBC chaining (default build is ECB only).
module aes_block_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_encrypt,
  input  logic [127:0]     cfg_key,
  input  logic             iv_load,
  input  logic [127:0]     iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             core_start,
  output logic             core_encrypt,
  output logic [127:0]     core_data,
  output logic [127:0]     core_key,
  input  logic             core_done,
  input  logic [127:0]     core_result,
  output logic [CNT_W-1:0] blk_count,
  output logic             err
);
  localparam int              WC_W    = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [127:0]     core_data_q, core_data_d;
  logic [127:0]     core_key_q, core_key_d;
  logic             core_enc_q, core_enc_d;
  logic [127:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] blk_count_q, blk_count_d;
  logic             err_q, err_d;
  logic             accept, iv_take, done_ok;
  logic [127:0]     blk_in, blk_out;

  // in_ready is forced low while reset is asserted, not just by the IDLE state.
  assign in_ready = rst_n && (state_q == S_IDLE) && !iv_load;
  assign accept   = in_valid && in_ready;
  assign iv_take  = (state_q == S_IDLE) && iv_load;
  assign done_ok  = (state_q == S_WAIT) && core_done;

`ifdef AES_SEQ_CBC_EN
  logic [127:0] chain_q, chain_d;
  logic [127:0] pend_q, pend_d;

  assign blk_in  = cfg_encrypt ? (in_data ^ chain_q) : in_data;
  assign blk_out = core_enc_q ? core_result : (core_result ^ chain_q);

  // Decrypt chains on the ciphertext, held in pend_q until the block completes.
  always_comb begin
    chain_d = chain_q;
    pend_d  = pend_q;
    if (iv_take) chain_d = iv;
    if (accept)  pend_d  = in_data;
    if (done_ok) chain_d = core_enc_q ? core_result : pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      pend_q  <= '0;
    end else begin
      chain_q <= chain_d;
      pend_q  <= pend_d;
    end
  end
`else
  logic [127:0] unused_iv;
  assign unused_iv = iv;
  assign blk_in    = in_data;
  assign blk_out   = core_result;
`endif

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    core_data_d = core_data_q;
    core_key_d  = core_key_q;
    core_enc_d  = core_enc_q;
    out_data_d  = out_data_q;
    blk_count_d = blk_count_q;
    err_d       = err_q;
    if (iv_take) err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          core_data_d = blk_in;
          core_key_d  = cfg_key;
          core_enc_d  = cfg_encrypt;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      // core_done takes priority over the watchdog terminal count.
      S_WAIT: begin
        if (done_ok) begin
          out_data_d  = blk_out;
          blk_count_d = blk_count_q + CNT_W'(1);
          state_d     = S_OUT;
        end else if (wcnt_q == WC_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      core_data_q <= '0;
      core_key_q  <= '0;
      core_enc_q  <= 1'b0;
      out_data_q  <= '0;
      blk_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      core_data_q <= core_data_d;
      core_key_q  <= core_key_d;
      core_enc_q  <= core_enc_d;
      out_data_q  <= out_data_d;
      blk_count_q <= blk_count_d;
      err_q       <= err_d;
    end
  end

  assign out_valid    = (state_q == S_OUT);
  assign core_start   = (state_q == S_ISSUE);
  assign core_encrypt = core_enc_q;
  assign core_data    = core_data_q;
  assign core_key     = core_key_q;
  assign out_data     = out_data_q;
  assign blk_count    = blk_count_q;
  assign err          = err_q;
endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer: stub AES core, expected results queued at acceptance.
module tb_aes_block_sequencer;
  localparam int P  = 10;
  localparam int CW = 3;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  // NIST SP 800-38A F.2.1 CBC-AES128.Encrypt, block 1 (plaintext, cipher input, ciphertext).
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] I2  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] C2  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] KB  = 128'hdeadbeef0badf00dcafebabe12345678;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           cfg_encrypt = 1'b0, iv_load = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [127:0]   cfg_key = '0, iv = '0, in_data = '0;
  logic           in_ready, out_valid, core_start, core_encrypt, core_done = 1'b0, err;
  logic [127:0]   out_data, core_data, core_key, core_result = '0;
  logic [CW-1:0]  blk_count;

  typedef struct {
    logic [127:0]  data;
    logic [CW-1:0] cnt;
    time           acc;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0, errors = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit            core_en = 1'b1, spur = 1'b0;
  int            starts = 0;
`ifdef AES_SEQ_CBC_EN
  logic [127:0]  m_chain = '0;
`endif

  always #(P/2) clk = ~clk;

  aes_block_sequencer #(.TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_encrypt(cfg_encrypt), .cfg_key(cfg_key),
    .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_encrypt(core_encrypt), .core_data(core_data),
    .core_key(core_key), .core_done(core_done), .core_result(core_result),
    .blk_count(blk_count), .err(err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stub core: known vectors by table, otherwise an arbitrary reversible-looking mix.
  function automatic logic [127:0] core_fn(input logic [127:0] k, d, input logic e);
    if (e && k == K1 && d == P1)  return C1;
    if (!e && k == K1 && d == C1) return P1;
    if (e && k == K2 && d == I2)  return C2;
    if (!e && k == K2 && d == C2) return I2;
    return {d[63:0], d[127:64]} ^ k ^ (e ? 128'h0 : {128{1'b1}});
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, k, input logic e);
    logic [127:0] r;
`ifdef AES_SEQ_CBC_EN
    if (e) begin
      r = core_fn(k, d ^ m_chain, 1'b1);
      m_chain = r;
    end else begin
      r = core_fn(k, d, 1'b0) ^ m_chain;
      m_chain = d;
    end
`else
    r = core_fn(k, d, e);
`endif
    return r;
  endfunction

  // Two-cycle core: start seen in cycle E0-E1, done driven for cycle E2-E3.
  task automatic core_model();
    int cnt = 0;
    logic [127:0] lk, ld;
    logic le;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (spur) begin
          core_done = 1'b1;
          core_result = '1;
          spur = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            core_done = 1'b1;
            core_result = core_fn(lk, ld, le);
          end
        end
        if (core_start) begin
          starts++;
          if (core_en) begin
            cnt = 2;
            lk = core_key;
            ld = core_data;
            le = core_encrypt;
          end
        end
      end
    end
  endtask

  task automatic monitor();
    logic prev_v = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          chk("out_has_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("out_latency", $time - exp_q[0].acc, 3*P + P/2);
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("blk_count", blk_count, e.cnt);
        end
        prev_v = out_valid;
      end
    end
  endtask

  task automatic send(input logic [127:0] d, k, input logic e, input bit expect_out,
                      input logic [127:0] exp_d, output time t_acc);
    bit ok = 1'b0;
    @(negedge clk);
    in_data = d; cfg_key = k; cfg_encrypt = e; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ok = in_ready;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    chk("accept", ok, 1);
    t_acc = $time;
    if (ok && expect_out) begin
      exp_cnt++;
      exp_q.push_back('{exp_d, exp_cnt, $time});
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic iv_pulse(input logic [127:0] v);
    @(negedge clk);
    iv = v; iv_load = 1'b1;
    #1 chk("iv_load_blocks_in", in_ready, 0);
    @(negedge clk);
    iv_load = 1'b0;
`ifdef AES_SEQ_CBC_EN
    m_chain = v;
`endif
  endtask

  task automatic wait_out();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_encrypt"}, core_encrypt, 0);
    chk({tag, "_core_data"}, core_data, 0);
    chk({tag, "_core_key"}, core_key, 0);
    chk({tag, "_blk_count"}, blk_count, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    time t, t_prev;
    int s0;
    logic [127:0] d;
    logic e;
    fork
      core_model();
      monitor();
      begin
        #(20000*P);
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench watchdog expired");
      end
    join_none

    #1 chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_after_rst", in_ready, 1);

    // ECB encrypt, FIPS-197 vector
    iv_pulse('0);
    send(P1, K1, 1'b1, 1'b1, C1, t);
    chk("enc_core_data", core_data, P1);
    chk("enc_core_key", core_key, K1);
    chk("enc_core_encrypt", core_encrypt, 1);
    drain();
    chk("core_data_held", core_data, P1);

    // ECB decrypt with a 10-cycle downstream stall
    iv_pulse('0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(C1, K1, 1'b0, 1'b1, P1, t);
    chk("dec_core_encrypt", core_encrypt, 0);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out_data", out_data, P1);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Watchdog: WAIT entered one edge after acceptance, err 16 edges later
    core_en = 1'b0;
    send(P1 ^ K1, K1, 1'b1, 1'b0, '0, t);
    repeat (17) @(negedge clk);
    chk("err_before_timeout", err, 0);
    @(negedge clk);
    chk("err_at_timeout", err, 1);
    chk("timeout_blk_count", blk_count, exp_cnt);
    chk("timeout_back_idle", in_ready, 1);
    core_en = 1'b1;
    iv_pulse('0);
    chk("iv_load_clears_err", err, 0);

    // Stray done pulse while idle
    @(negedge clk);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    chk("spur_blk_count", blk_count, exp_cnt);
    chk("spur_out_valid", out_valid, 0);

    // Asynchronous reset while waiting on the core
    send(P1, K1, 1'b1, 1'b0, '0, t);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_cnt = '0;
`ifdef AES_SEQ_CBC_EN
    m_chain = '0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(P1, K1, 1'b1, 1'b1, C1, t);
    drain();

    // Back-to-back blocks; count runs 1 -> 8, wrapping to 0 at CNT_W=3
    s0 = starts;
    for (int i = 0; i < 7; i++) begin
      d = {4{32'h1000_0000 + 32'(i)}};
      e = i[0];
      send(d, KB, e, 1'b1, model(d, KB, e), t);
      if (i > 0) chk("b2b_period", t - t_prev, 5*P);
      t_prev = t;
    end
    drain();
    chk("b2b_starts", starts - s0, 7);
    chk("blk_count_wrap", blk_count, 0);

`ifdef AES_SEQ_CBC_EN
    iv_pulse(IV2);
    send(P2, K2, 1'b1, 1'b1, C2, t);
    chk("cbc_core_data", core_data, I2);
    drain();
    iv_pulse(IV2);
    send(C2, K2, 1'b0, 1'b1, P2, t);
    chk("cbc_dec_core_data", core_data, C2);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
